mul_acc_stage: RTL and testbench
================================

# mul_acc_stage

Downstream consumer of the 32x32 signed multiplier: a handshaked multiply-accumulate stage that sums a stream of signed 64-bit products into a wide accumulator. A frame is a sequence of product beats terminated by `in_last`. The stage presents the frame total, beat count and overflow flag on a registered output port. It then clears itself for the next frame.

## Interface
- `ACC_W`, 64: accumulator and result width, signed; legal range 64..128.
- `CNT_W`, 16: beat-counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: stage can accept a beat.
- `product` in 64: signed product from the multiplier.
- `in_last` in 1: the current beat closes the frame.
- `acc_clear` in 1: discard the partial frame.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: consumer accepts the result.
- `acc_out` out ACC_W: signed frame sum.
- `out_count` out CNT_W: number of beats in the frame.
- `overflow` out 1: sticky signed-overflow flag for the frame.

## Operation
- FSM with two states: ACCUM and HOLD. Reset state is ACCUM.
- Beat accepted when `in_valid && in_ready`.
- `in_ready = (state==ACCUM) && !acc_clear`.
- On an accepted beat, update the accumulator: acc <= acc + sext(product, ACC_W).
- On an accepted beat, update the count: cnt <= cnt+1, saturating at all-ones.
- Signed overflow: both operands have the same sign and the sum sign differs. On overflow, the sticky flag `ovf` <= 1.
- Accepted beat with `in_last`:
  - the final sum (including this beat), final count and final `ovf` are loaded into the output registers;
  - internal acc, cnt and `ovf` are zeroed;
  - state -> HOLD.
- HOLD:
  - `out_valid`=1;
  - outputs are held stable until `out_valid && out_ready`, then state -> ACCUM;
  - no beats are accepted.
- `acc_clear` in ACCUM zeroes acc, cnt and `ovf`. Any beat presented in the same cycle is not accepted, since `in_ready` is 0.
- `acc_clear` in HOLD is ignored.
- A frame of a single beat with `in_last` is legal: result = sext(product), count = 1.

## Timing
- Reset values:
  - `in_ready`=1 (if `acc_clear`=0);
  - `out_valid`=0;
  - `acc_out`=0, `out_count`=0, `overflow`=0;
  - internal acc, cnt and `ovf` = 0.
- `rst` mid-frame or in HOLD aborts everything on the next edge; a pending result is lost.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, i.e. one cycle after that beat is presented.
- Throughput:
  - one beat per cycle inside a frame;
  - minimum one HOLD cycle per frame, taken when `out_ready` is already high;
  - the next frame's first beat can be accepted in the cycle after the output handshake.
- `in_ready` is combinational from state and `acc_clear`.
- `acc_out`, `out_count` and `overflow` are registered and change only on the `in_last` load or on reset.

## Configuration
- Macro: `MUL_ACC_SATURATE_EN`.
- Defined: on overflow, acc clamps to the signed max (0x7FF…F) or signed min (0x800…0) of ACC_W. The clamp direction follows the sign of the addend. Later beats continue from the clamped value. `overflow` still reports the event.
- Undefined: two's-complement wrap-around; `overflow` reports the event.

## Test plan
- Reset, then 3-beat frame 5, -7, 100 (last), `out_ready`=1:
  - `acc_out`=98, `out_count`=3, `overflow`=0;
  - `out_valid` high exactly one cycle.
- Back-pressure, single beat -1 with `in_last`, `out_ready`=0 for 4 cycles:
  - `acc_out`=-1 (all ones), `out_valid` held;
  - `in_ready`=0 throughout;
  - after the handshake, the next beat is accepted the following cycle.
- ACC_W=64, frame 0x7FFF_FFFF_FFFF_FFFF then 1 (last):
  - without the macro: `acc_out`=0x8000_0000_0000_0000, `overflow`=1;
  - with the macro: `acc_out`=0x7FFF_FFFF_FFFF_FFFF, `overflow`=1.
- Beats 10, 20, then `acc_clear` together with `in_valid` (beat 99 not accepted), then 7 (last):
  - `acc_out`=7, `out_count`=1.
- `rst` asserted during HOLD with `out_ready`=0:
  - next cycle `out_valid`=0, `acc_out`=0, `in_ready`=1.
- CNT_W=2, 5-beat frame of +1:
  - `out_count`=3 (saturated), `acc_out`=5.

Source files
------------

// File: rtl/mul_acc_stage.sv
// mul_acc_stage: handshaked multiply-accumulate stage summing signed 64-bit product frames.
// Optional MUL_ACC_SATURATE_EN clamps the accumulator on signed overflow instead of wrapping.
module mul_acc_stage #(
    parameter int ACC_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      product,
    input  logic             in_last,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow
);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic             ovf_q, ovf_d, rovf_q, rovf_d;
    logic [ACC_W-1:0] addend, sum, acc_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_now, accept;

    assign in_ready  = (state_q == ACCUM) && !acc_clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign acc_out   = res_q;
    assign out_count = rcnt_q;
    assign overflow  = rovf_q;

    assign addend  = ACC_W'($signed(product));
    assign sum     = acc_q + addend;
    assign ovf_now = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
`ifdef MUL_ACC_SATURATE_EN
    // Overflow direction always matches the addend's sign, so clamp toward it.
    assign acc_nxt = !ovf_now ? sum :
                     addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign acc_nxt = sum;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        rcnt_d  = rcnt_q;
        rovf_d  = rovf_q;
        if (state_q == ACCUM && acc_clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept && in_last) begin
            res_d   = acc_nxt;
            rcnt_d  = cnt_inc;
            rovf_d  = ovf_q | ovf_now;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = HOLD;
        end else if (accept) begin
            acc_d = acc_nxt;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | ovf_now;
        end else if (state_q == HOLD && out_ready) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            rcnt_q  <= '0;
            rovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            rcnt_q  <= rcnt_d;
            rovf_q  <= rovf_d;
        end
    end
endmodule

// File: tb/tb_mul_acc_stage.sv
// tb_mul_acc_stage: directed vector table plus hand-written back-pressure and reset sequences.
// A second instance with CNT_W=2 shares the stimulus to observe count saturation.
module tb_mul_acc_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, acc_clear, out_ready;
    logic [63:0] product;
    logic        in_ready, out_valid, overflow;
    logic [63:0] acc_out;
    logic [15:0] out_count;
    logic        in_ready2, out_valid2, overflow2;
    logic [63:0] acc_out2;
    logic [1:0]  out_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_acc_stage #(.ACC_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .in_last(in_last), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .out_count(out_count), .overflow(overflow)
    );

    mul_acc_stage #(.ACC_W(64), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .product(product), .in_last(in_last), .acc_clear(acc_clear),
        .out_valid(out_valid2), .out_ready(out_ready), .acc_out(acc_out2),
        .out_count(out_count2), .overflow(overflow2)
    );

    typedef struct {
        logic        v;
        logic [63:0] p;
        logic        l;
        logic        c;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [63:0] acc;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

`ifdef MUL_ACC_SATURATE_EN
    localparam logic [63:0] OVF_ACC = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] OVF_ACC = 64'h8000_0000_0000_0000;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic l, input logic c, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        product   = p;
        in_last   = l;
        acc_clear = c;
        out_ready = ordy;
        #1;
    endtask

    task automatic post_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [63:0] p, input logic l, input logic c, input logic ordy,
                       input logic ir, input logic ov, input logic [63:0] acc, input logic [15:0] cnt,
                       input logic [1:0] cnt2, input logic ovf);
        vec_t r;
        r.v = v; r.p = p; r.l = l; r.c = c; r.ordy = ordy;
        r.ir = ir; r.ov = ov; r.acc = acc; r.cnt = cnt; r.cnt2 = cnt2; r.ovf = ovf;
        tbl.push_back(r);
    endtask

    initial begin
        //   v  product                 l  c  ordy ir ov acc      cnt cnt2 ovf
        add(1, 64'd5,                   0, 0, 1,   1, 0, 64'd0,   0,  0,   0);
        add(1, -64'sd7,                 0, 0, 1,   1, 0, 64'd0,   0,  0,   0);
        add(1, 64'd100,                 1, 0, 1,   1, 1, 64'd98,  3,  3,   0);
        add(0, 64'd0,                   0, 0, 1,   0, 0, 64'd98,  3,  3,   0);
        add(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1,   1, 0, 64'd98,  3,  3,   0);
        add(1, 64'd1,                   1, 0, 1,   1, 1, OVF_ACC, 2,  2,   1);
        add(0, 64'd0,                   0, 0, 1,   0, 0, OVF_ACC, 2,  2,   1);
        add(1, 64'd10,                  0, 0, 1,   1, 0, OVF_ACC, 2,  2,   1);
        add(1, 64'd20,                  0, 0, 1,   1, 0, OVF_ACC, 2,  2,   1);
        add(1, 64'd99,                  0, 1, 1,   0, 0, OVF_ACC, 2,  2,   1);
        add(1, 64'd7,                   1, 0, 1,   1, 1, 64'd7,   1,  1,   0);
        add(0, 64'd0,                   0, 0, 1,   0, 0, 64'd7,   1,  1,   0);
        add(1, 64'd1,                   0, 0, 1,   1, 0, 64'd7,   1,  1,   0);
        add(1, 64'd1,                   0, 0, 1,   1, 0, 64'd7,   1,  1,   0);
        add(1, 64'd1,                   0, 0, 1,   1, 0, 64'd7,   1,  1,   0);
        add(1, 64'd1,                   0, 0, 1,   1, 0, 64'd7,   1,  1,   0);
        add(1, 64'd1,                   1, 0, 1,   1, 1, 64'd5,   5,  3,   0);
        add(0, 64'd0,                   0, 0, 1,   0, 0, 64'd5,   5,  3,   0);

        rst = 1'b1;
        drive(0, 64'd0, 0, 0, 1);
        post_edge();
        post_edge();
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_acc_out", acc_out, 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].c, tbl[i].ordy);
            check($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            post_edge();
            check($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            check($sformatf("row%0d_acc_out", i), acc_out, tbl[i].acc);
            check($sformatf("row%0d_out_count", i), 64'(out_count), 64'(tbl[i].cnt));
            check($sformatf("row%0d_out_count_w2", i), 64'(out_count2), 64'(tbl[i].cnt2));
            check($sformatf("row%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
        end

        // Back-pressure: single -1 beat held while the consumer stalls.
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        check("bp_accept_ready", 64'(in_ready), 64'd1);
        post_edge();
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_acc_out", acc_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bp_out_count", 64'(out_count), 64'd1);
        for (int k = 0; k < 4; k++) begin
            drive(1, 64'd3, 0, 1, 0);
            check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            post_edge();
            check($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_acc_out", k), acc_out, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        drive(1, 64'd3, 1, 0, 1);
        check("bp_handshake_in_ready", 64'(in_ready), 64'd0);
        post_edge();
        check("bp_handshake_out_valid", 64'(out_valid), 64'd0);
        drive(1, 64'd4, 1, 0, 0);
        check("bp_next_in_ready", 64'(in_ready), 64'd1);
        post_edge();
        check("bp_next_out_valid", 64'(out_valid), 64'd1);
        check("bp_next_acc_out", acc_out, 64'd4);
        check("bp_next_out_count", 64'(out_count), 64'd1);

        // Reset while holding an unconsumed result.
        drive(0, 64'd0, 0, 0, 0);
        rst = 1'b1;
        post_edge();
        rst = 1'b0;
        check("rst_hold_out_valid", 64'(out_valid), 64'd0);
        check("rst_hold_acc_out", acc_out, 64'd0);
        check("rst_hold_out_count", 64'(out_count), 64'd0);
        check("rst_hold_in_ready", 64'(in_ready), 64'd1);
        drive(1, 64'd9, 1, 0, 1);
        post_edge();
        check("rst_after_acc_out", acc_out, 64'd9);
        check("rst_after_out_count", 64'(out_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
